// File: rtl/otter_hazard_ctrl_if.sv
// Hazard-controller bundle: decode operand info, EX redirect and interrupt
// inputs in; STALL / FLUSH / INT_TAKEN, forward selects and counters out.
// Modports: slave = hazard controller, master = pipeline side driving it.
interface otter_hazard_ctrl_if #(
   parameter int FS_W  = 2,
   parameter int CNT_W = 32
);
   logic             DE_VALID;
   logic [4:0]       DE_RS1_ADDR;
   logic [4:0]       DE_RS2_ADDR;
   logic             DE_RS1_USED;
   logic             DE_RS2_USED;
   logic [4:0]       DE_RD_ADDR;
   logic             DE_REG_WRITE;
   logic             DE_MEM_READ;
   logic             EX_REDIRECT;
   logic             INTR;
   logic             MIE;
   logic             INT_CLR;
   logic             STALL;
   logic             FLUSH;
   logic             INT_TAKEN;
   logic [FS_W-1:0]  FWD_A;
   logic [FS_W-1:0]  FWD_B;
   logic [CNT_W-1:0] STALL_CNT;
   logic [CNT_W-1:0] FLUSH_CNT;

   modport slave (
      input  DE_VALID, DE_RS1_ADDR, DE_RS2_ADDR, DE_RS1_USED, DE_RS2_USED,
             DE_RD_ADDR, DE_REG_WRITE, DE_MEM_READ, EX_REDIRECT, INTR, MIE, INT_CLR,
      output STALL, FLUSH, INT_TAKEN, FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
   );

   modport master (
      output DE_VALID, DE_RS1_ADDR, DE_RS2_ADDR, DE_RS1_USED, DE_RS2_USED,
             DE_RD_ADDR, DE_REG_WRITE, DE_MEM_READ, EX_REDIRECT, INTR, MIE, INT_CLR,
      input  STALL, FLUSH, INT_TAKEN, FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
   );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// OTTER hazard/forwarding controller: shadow pipeline of in-flight destinations,
// load-use stall, flush sequencer for redirects/interrupts, stall/flush counters.
// Latency: STALL/FLUSH/INT_TAKEN/FWD_* combinational (0 cycles); no backpressure input.
// Ports: CLK, RESET_N (async active-low); hz (slave) carries decode operands,
//        EX_REDIRECT, INTR/MIE/INT_CLR in and STALL, FLUSH, INT_TAKEN, FWD_A/B,
//        STALL_CNT/FLUSH_CNT out.
module otter_hazard_ctrl #(
   parameter int NUM_FWD_STAGES = 2,
   parameter int LOAD_LAT       = 1,
   parameter int FLUSH_CYCLES   = 1,
   parameter int CNT_W          = 32,
   parameter int FS_W           = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic               CLK,
   input  logic               RESET_N,
   otter_hazard_ctrl_if.slave hz
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       reg_write;
      logic       is_load;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
   } shadow_t;

   // Entry 0 is EX, entry k is k stages after EX.
   shadow_t          r_pipe [0:NUM_FWD_STAGES];
   logic [2:0]       r_fcnt;
   logic             r_pend;
   logic             r_int_busy;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   shadow_t          w_de;
   logic             w_load_hit;
   logic             w_stall_raw;
   logic             w_flush_busy;
   logic             w_int_taken;
   logic             w_trigger;
   logic             w_flush;
   logic             w_stall;
   logic [FS_W-1:0]  w_fwd_a;
   logic [FS_W-1:0]  w_fwd_b;

   function automatic logic f_match(input shadow_t p, input logic [4:0] src, input logic used);
      return p.valid && p.reg_write && (p.rd == src) && (p.rd != 5'd0) && used;
   endfunction

   always_comb begin
      w_de           = '0;
      w_de.valid     = 1'b1;
      w_de.rd        = hz.DE_RD_ADDR;
      w_de.reg_write = hz.DE_REG_WRITE;
      w_de.is_load   = hz.DE_MEM_READ;
      w_de.rs1       = hz.DE_RS1_ADDR;
      w_de.rs2       = hz.DE_RS2_ADDR;
      w_de.rs1_used  = hz.DE_RS1_USED;
      w_de.rs2_used  = hz.DE_RS2_USED;
   end

   // Loads younger than LOAD_LAT stages have no forwardable data yet.
   always_comb begin
      w_load_hit = 1'b0;
      for (int s = 0; s < LOAD_LAT; s++) begin
         if (r_pipe[s].is_load &&
             (f_match(r_pipe[s], hz.DE_RS1_ADDR, hz.DE_RS1_USED) ||
              f_match(r_pipe[s], hz.DE_RS2_ADDR, hz.DE_RS2_USED)))
            w_load_hit = 1'b1;
      end
   end

   // The interrupt qualifier uses the stall and flush terms that do not
   // depend on INT_TAKEN itself, which breaks the combinational loop.
   assign w_stall_raw  = hz.DE_VALID & w_load_hit;
   assign w_flush_busy = (r_fcnt != 3'd0);
   assign w_int_taken  = r_pend & ~w_stall_raw & ~w_flush_busy & ~hz.EX_REDIRECT & ~r_int_busy;
   assign w_trigger    = hz.EX_REDIRECT | w_int_taken;
   assign w_flush      = w_trigger | w_flush_busy;
   assign w_stall      = w_stall_raw & ~w_flush;

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      w_fwd_a = '0;
      w_fwd_b = '0;
      if (r_pipe[0].valid) begin
         for (int k = NUM_FWD_STAGES; k >= 1; k--) begin
            if (f_match(r_pipe[k], r_pipe[0].rs1, r_pipe[0].rs1_used))
               w_fwd_a = FS_W'(k);
            if (f_match(r_pipe[k], r_pipe[0].rs2, r_pipe[0].rs2_used))
               w_fwd_b = FS_W'(k);
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int k = 0; k <= NUM_FWD_STAGES; k++)
            r_pipe[k] <= '0;
         r_fcnt      <= 3'd0;
         r_pend      <= 1'b0;
         r_int_busy  <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_pipe[0] <= (hz.DE_VALID && !w_stall && !w_flush) ? w_de : '0;
         for (int k = 1; k <= NUM_FWD_STAGES; k++)
            r_pipe[k] <= r_pipe[k-1];

         // Retrigger mid-flush reloads the full remaining length.
         if (w_trigger)
            r_fcnt <= 3'(FLUSH_CYCLES - 1);
         else if (w_flush_busy)
            r_fcnt <= r_fcnt - 3'd1;

         if (hz.INT_CLR)
            r_pend <= 1'b0;
         else if (hz.INTR && hz.MIE)
            r_pend <= 1'b1;

         if (hz.INT_CLR)
            r_int_busy <= 1'b0;
         else if (w_int_taken)
            r_int_busy <= 1'b1;

         r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall);
         r_flush_cnt <= r_flush_cnt + CNT_W'(w_flush);
      end
   end

   assign hz.STALL     = w_stall;
   assign hz.FLUSH     = w_flush;
   assign hz.INT_TAKEN = w_int_taken;
   assign hz.FWD_A     = w_fwd_a;
   assign hz.FWD_B     = w_fwd_b;
   assign hz.STALL_CNT = r_stall_cnt;
   assign hz.FLUSH_CNT = r_flush_cnt;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl: two configurations (2/1/1 and 3/2/2) share one
// stimulus stream; a history-based reference model queues expectations that a
// separate monitor compares against each DUT's outputs.
module tb_otter_hazard_ctrl;

   localparam int NF [2] = '{2, 3};
   localparam int LL [2] = '{1, 2};
   localparam int FC [2] = '{1, 2};

   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       u1;
      bit       u2;
   } ins_t;

   typedef struct {
      bit       dv;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit [4:0] rd;
      bit       u1;
      bit       u2;
      bit       wr;
      bit       ld;
      bit       redir;
      bit       intr;
      bit       mie;
      bit       clr;
   } stim_t;

   typedef struct {
      int        m;
      bit        stall;
      bit        flush;
      bit        take;
      int        fa;
      int        fb;
      bit [31:0] sc;
      bit [31:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   otter_hazard_ctrl_if #(.FS_W(2), .CNT_W(32)) hif_a ();
   otter_hazard_ctrl_if #(.FS_W(2), .CNT_W(32)) hif_b ();

   otter_hazard_ctrl #(.NUM_FWD_STAGES(2), .LOAD_LAT(1), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
      .CLK(clk), .RESET_N(rst_n), .hz(hif_a)
   );
   otter_hazard_ctrl #(.NUM_FWD_STAGES(3), .LOAD_LAT(2), .FLUSH_CYCLES(2), .CNT_W(32)) dut_b (
      .CLK(clk), .RESET_N(rst_n), .hz(hif_b)
   );

   // Reference state: hist[m][k] = instruction that issued into EX k cycles ago.
   ins_t      hist [2][0:7];
   longint    cyc;
   longint    flush_end [2];
   bit        pend [2];
   bit        busy [2];
   bit [31:0] scnt [2];
   bit [31:0] fcnt [2];

   exp_t exp_q [$];
   event ev_drv;
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic bit writes(input ins_t p, input bit [4:0] a, input bit u);
      return p.v && p.wr && (p.rd == a) && (a != 5'd0) && u;
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 8; k++) hist[m][k] = '{default: 0};
         flush_end[m] = 0;
         pend[m] = 0;
         busy[m] = 0;
         scnt[m] = 0;
         fcnt[m] = 0;
      end
      cyc = 0;
   endtask

   task automatic model_step(input stim_t s);
      for (int m = 0; m < 2; m++) begin
         exp_t e;
         bit   raw, fbusy, fa_found, fb_found;
         ins_t ni;
         e = '{default: 0};
         e.m = m;
         raw = 0;
         if (s.dv)
            for (int k = 0; k < LL[m]; k++)
               if (hist[m][k].ld && (writes(hist[m][k], s.rs1, s.u1) || writes(hist[m][k], s.rs2, s.u2)))
                  raw = 1;
         fbusy   = (cyc < flush_end[m]);
         e.take  = pend[m] && !raw && !fbusy && !s.redir && !busy[m];
         e.flush = s.redir || e.take || fbusy;
         e.stall = raw && !e.flush;
         fa_found = 0;
         fb_found = 0;
         if (hist[m][0].v) begin
            for (int k = 1; k <= NF[m]; k++) begin
               if (!fa_found && writes(hist[m][k], hist[m][0].rs1, hist[m][0].u1)) begin
                  e.fa = k;
                  fa_found = 1;
               end
               if (!fb_found && writes(hist[m][k], hist[m][0].rs2, hist[m][0].u2)) begin
                  e.fb = k;
                  fb_found = 1;
               end
            end
         end
         e.sc = scnt[m];
         e.fc = fcnt[m];
         exp_q.push_back(e);

         for (int k = 7; k >= 1; k--) hist[m][k] = hist[m][k-1];
         ni = '{default: 0};
         if (s.dv && !e.stall && !e.flush)
            ni = '{1'b1, s.rd, s.wr, s.ld, s.rs1, s.rs2, s.u1, s.u2};
         hist[m][0] = ni;
         if (s.redir || e.take) flush_end[m] = cyc + FC[m];
         if (s.clr) pend[m] = 0; else if (s.intr && s.mie) pend[m] = 1;
         if (s.clr) busy[m] = 0; else if (e.take) busy[m] = 1;
         scnt[m] = scnt[m] + 32'(e.stall);
         fcnt[m] = fcnt[m] + 32'(e.flush);
      end
      cyc++;
   endtask

   task automatic apply(input stim_t s);
      hif_a.DE_VALID = s.dv;     hif_b.DE_VALID = s.dv;
      hif_a.DE_RS1_ADDR = s.rs1; hif_b.DE_RS1_ADDR = s.rs1;
      hif_a.DE_RS2_ADDR = s.rs2; hif_b.DE_RS2_ADDR = s.rs2;
      hif_a.DE_RS1_USED = s.u1;  hif_b.DE_RS1_USED = s.u1;
      hif_a.DE_RS2_USED = s.u2;  hif_b.DE_RS2_USED = s.u2;
      hif_a.DE_RD_ADDR = s.rd;   hif_b.DE_RD_ADDR = s.rd;
      hif_a.DE_REG_WRITE = s.wr; hif_b.DE_REG_WRITE = s.wr;
      hif_a.DE_MEM_READ = s.ld;  hif_b.DE_MEM_READ = s.ld;
      hif_a.EX_REDIRECT = s.redir; hif_b.EX_REDIRECT = s.redir;
      hif_a.INTR = s.intr;       hif_b.INTR = s.intr;
      hif_a.MIE = s.mie;         hif_b.MIE = s.mie;
      hif_a.INT_CLR = s.clr;     hif_b.INT_CLR = s.clr;
   endtask

   task automatic run(input stim_t s);
      @(negedge clk);
      apply(s);
      model_step(s);
      -> ev_drv;
   endtask

   // Reset lands mid-cycle so any in-progress flush/stall state must clear asynchronously.
   task automatic do_reset();
      stim_t z;
      exp_t  e;
      z = '{default: 0};
      @(negedge clk);
      apply(z);
      #2 rst_n = 1'b0;
      for (int m = 0; m < 2; m++) begin
         e = '{default: 0};
         e.m = m;
         exp_q.push_back(e);
      end
      model_reset();
      -> ev_drv;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic stim_t op(input bit [4:0] rd, input bit wr, input bit ld,
                                input bit [4:0] rs1, input bit u1,
                                input bit [4:0] rs2, input bit u2);
      stim_t s;
      s = '{default: 0};
      s.dv = 1; s.rd = rd; s.wr = wr; s.ld = ld;
      s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
      return s;
   endfunction

   function automatic stim_t nop();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic check(input string nm, input int m, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d", nm, m, cyc, act, req);
      end
   endtask

   // Monitor: every driven cycle both DUTs present outputs; pop and compare.
   initial begin
      exp_t e;
      logic l_st, l_fl, l_tk;
      logic [31:0] l_fa, l_fb, l_sc, l_fc;
      forever begin
         @(ev_drv);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
            end else begin
               e = exp_q.pop_front();
               if (e.m == 0) begin
                  l_st = hif_a.STALL; l_fl = hif_a.FLUSH; l_tk = hif_a.INT_TAKEN;
                  l_fa = 32'(hif_a.FWD_A); l_fb = 32'(hif_a.FWD_B);
                  l_sc = hif_a.STALL_CNT; l_fc = hif_a.FLUSH_CNT;
               end else begin
                  l_st = hif_b.STALL; l_fl = hif_b.FLUSH; l_tk = hif_b.INT_TAKEN;
                  l_fa = 32'(hif_b.FWD_A); l_fb = 32'(hif_b.FWD_B);
                  l_sc = hif_b.STALL_CNT; l_fc = hif_b.FLUSH_CNT;
               end
               check("stall",     e.m, {31'd0, l_st}, {31'd0, e.stall});
               check("flush",     e.m, {31'd0, l_fl}, {31'd0, e.flush});
               check("int_taken", e.m, {31'd0, l_tk}, {31'd0, e.take});
               check("fwd_a",     e.m, l_fa, 32'(e.fa));
               check("fwd_b",     e.m, l_fb, 32'(e.fb));
               check("stall_cnt", e.m, l_sc, e.sc);
               check("flush_cnt", e.m, l_fc, e.fc);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_t s;
      model_reset();
      apply(nop());
      do_reset();

      // ALU back-to-back: add x5; sub x6,x5,x1; gap; use of x5 two slots later.
      run(op(5, 1, 0, 1, 1, 2, 1));
      run(op(6, 1, 0, 5, 1, 1, 1));
      run(nop());
      run(op(9, 1, 0, 5, 1, 0, 1));
      repeat (4) run(nop());

      // Load-use: lw x7; add x8,x7,x7 held for the longest stall.
      run(op(7, 1, 1, 2, 1, 0, 0));
      repeat (3) run(op(8, 1, 0, 7, 1, 7, 1));
      repeat (5) run(nop());

      // x0 writer/reader and a matching but unused rs2.
      run(op(0, 1, 1, 1, 1, 0, 0));
      run(op(3, 1, 1, 0, 1, 0, 0));
      run(op(10, 1, 0, 0, 1, 3, 0));
      repeat (4) run(nop());

      // Youngest producer wins.
      run(op(5, 1, 0, 1, 1, 0, 0));
      run(op(5, 1, 0, 2, 1, 0, 0));
      run(op(11, 1, 0, 5, 1, 5, 1));
      repeat (4) run(nop());

      // Redirect arriving in a load-use stall cycle.
      run(op(7, 1, 1, 2, 1, 0, 0));
      s = op(8, 1, 0, 7, 1, 7, 1);
      s.redir = 1;
      run(s);
      s.redir = 0;
      repeat (2) run(s);
      repeat (4) run(nop());

      // Interrupt: single take until acknowledged, then taken again.
      s = nop();
      s.intr = 1; s.mie = 1;
      repeat (5) run(s);
      s.clr = 1;
      run(s);
      s.clr = 0;
      repeat (4) run(s);
      s.clr = 1; s.intr = 0;
      run(s);

      // Reset asserted while a flush is in progress.
      s = nop();
      s.redir = 1;
      run(s);
      do_reset();

      for (int i = 0; i < 4000; i++) begin
         s = nop();
         s.dv    = ($urandom_range(0, 9) < 8);
         s.rs1   = 5'($urandom_range(0, 3));
         s.rs2   = 5'($urandom_range(0, 3));
         s.rd    = 5'($urandom_range(0, 3));
         s.u1    = ($urandom_range(0, 9) < 8);
         s.u2    = ($urandom_range(0, 9) < 7);
         s.wr    = ($urandom_range(0, 9) < 7);
         s.ld    = ($urandom_range(0, 9) < 3);
         s.redir = ($urandom_range(0, 19) == 0);
         s.intr  = ($urandom_range(0, 3) == 0);
         s.mie   = ($urandom_range(0, 3) != 0);
         s.clr   = ($urandom_range(0, 15) == 0);
         run(s);
         if (i == 2000) do_reset();
      end

      @(negedge clk);
      #3;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
